// File: rtl/rbm_instr_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rbm_instr_encoder_if                                          |
// | Brief    : Abstract RBM instruction request bus (op + Configure payload) |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface rbm_instr_encoder_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic [31:0] instr_conf_num_hidden;
    logic [31:0] instr_conf_num_loops;
    logic [31:0] instr_conf_num_movies;
    logic [31:0] instr_conf_num_testusers;
    logic [31:0] instr_conf_num_users;
    logic [31:0] instr_conf_num_visible;

    modport master (
        output instr_valid, instr_op,
        output instr_conf_num_hidden, instr_conf_num_loops, instr_conf_num_movies,
        output instr_conf_num_testusers, instr_conf_num_users, instr_conf_num_visible,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op,
        input  instr_conf_num_hidden, instr_conf_num_loops, instr_conf_num_movies,
        input  instr_conf_num_testusers, instr_conf_num_users, instr_conf_num_visible,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/rbm_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rbm_instr_encoder                                             |
// | Brief    : Turns abstract RBM Reset/Configure instructions into RBM pins  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rbm_instr_encoder #(
    parameter int RST_CYCLES  = 2,
    parameter int CONF_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rbm_instr_encoder_if.slave instr,
    output logic               dut_rst,
    output logic               dut_conf_done,
    output logic [31:0]        dut_conf_num_hidden,
    output logic [31:0]        dut_conf_num_loops,
    output logic [31:0]        dut_conf_num_movies,
    output logic [31:0]        dut_conf_num_testusers,
    output logic [31:0]        dut_conf_num_users,
    output logic [31:0]        dut_conf_num_visible,
    output logic               issue,
    output logic               prev_reset,
    output logic               prev_conf,
    output logic               err_seq,
    output logic               err_op,
    output logic [15:0]        instr_count
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_RST_DRV  = 2'd1;
    localparam logic [1:0]  c_CONF_DRV = 2'd2;
    localparam logic [1:0]  c_GAP      = 2'd3;

    localparam logic [15:0] c_RST_LOAD  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] c_CONF_LOAD = 16'(CONF_CYCLES - 1);
    localparam logic [15:0] c_GAP_LOAD  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_ready;
    logic        r_dut_rst;
    logic        r_conf_done;
    logic [31:0] r_num_hidden;
    logic [31:0] r_num_loops;
    logic [31:0] r_num_movies;
    logic [31:0] r_num_testusers;
    logic [31:0] r_num_users;
    logic [31:0] r_num_visible;
    logic        r_issue;
    logic        r_prev_reset;
    logic        r_prev_conf;
    logic        r_err_seq;
    logic        r_err_op;
    logic [15:0] r_instr_count;

    logic        w_hs;
    logic        w_acc_rst;
    logic        w_acc_conf;
    logic        w_rej_seq;
    logic        w_rej_op;

    // r_ready is only ever high in IDLE, so a handshake implies IDLE.
    assign w_hs       = instr.instr_valid && r_ready;
    assign w_acc_rst  = w_hs && (instr.instr_op == 2'd0);
    assign w_acc_conf = w_hs && (instr.instr_op == 2'd1) && !r_prev_conf;
    assign w_rej_seq  = w_hs && (instr.instr_op == 2'd1) && r_prev_conf;
    assign w_rej_op   = w_hs && instr.instr_op[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_acc_rst) begin
                    w_state_nxt = c_RST_DRV;
                    w_cnt_nxt   = c_RST_LOAD;
                end else if (w_acc_conf) begin
                    w_state_nxt = c_CONF_DRV;
                    w_cnt_nxt   = c_CONF_LOAD;
                end
            end
            c_RST_DRV, c_CONF_DRV: begin
                if (r_cnt == 16'd0) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            c_GAP: begin
                if (r_cnt == 16'd0) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_cnt           <= 16'd0;
            r_ready         <= 1'b0;
            r_dut_rst       <= 1'b0;
            r_conf_done     <= 1'b0;
            r_num_hidden    <= 32'd0;
            r_num_loops     <= 32'd0;
            r_num_movies    <= 32'd0;
            r_num_testusers <= 32'd0;
            r_num_users     <= 32'd0;
            r_num_visible   <= 32'd0;
            r_issue         <= 1'b0;
            r_prev_reset    <= 1'b0;
            r_prev_conf     <= 1'b0;
            r_err_seq       <= 1'b0;
            r_err_op        <= 1'b0;
            r_instr_count   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= (w_state_nxt == c_IDLE);
            r_dut_rst   <= (w_state_nxt != c_RST_DRV);
            r_conf_done <= (w_state_nxt == c_CONF_DRV);
            r_issue     <= w_acc_rst || w_acc_conf;
            r_err_seq   <= w_rej_seq;
            r_err_op    <= w_rej_op;
            if (w_acc_rst || w_acc_conf) begin
                r_prev_reset  <= w_acc_rst;
                r_prev_conf   <= w_acc_conf;
                r_instr_count <= r_instr_count + 16'd1;
            end
            if (w_acc_conf) begin
                r_num_hidden    <= instr.instr_conf_num_hidden;
                r_num_loops     <= instr.instr_conf_num_loops;
                r_num_movies    <= instr.instr_conf_num_movies;
                r_num_testusers <= instr.instr_conf_num_testusers;
                r_num_users     <= instr.instr_conf_num_users;
                r_num_visible   <= instr.instr_conf_num_visible;
            end
        end
    end

    assign instr.instr_ready    = r_ready;
    assign dut_rst              = r_dut_rst;
    assign dut_conf_done        = r_conf_done;
    assign dut_conf_num_hidden    = r_num_hidden;
    assign dut_conf_num_loops     = r_num_loops;
    assign dut_conf_num_movies    = r_num_movies;
    assign dut_conf_num_testusers = r_num_testusers;
    assign dut_conf_num_users     = r_num_users;
    assign dut_conf_num_visible   = r_num_visible;
    assign issue                = r_issue;
    assign prev_reset           = r_prev_reset;
    assign prev_conf            = r_prev_conf;
    assign err_seq              = r_err_seq;
    assign err_op               = r_err_op;
    assign instr_count          = r_instr_count;

endmodule
`default_nettype wire

// File: doc/rbm_instr_encoder.md
# rbm_instr_encoder

Stimulus-side counterpart of the RBM A-QED instruction decoder: accepts abstract RBM ILA instructions (Reset, Configure) over a valid/ready port and drives the RBM accelerator's control pins (`rst`, `conf_done`, `conf_num_*`) so that each instruction decodes correctly. It also emits the matching one-cycle `issue` strobe and previous-instruction flags. It enforces the legal ordering rule at the source: Configure is legal only as the first instruction or directly after a Reset. The block sits between the A-QED harness sequencer and the RBM DUT.

## Interface
Parameters:
- `RST_CYCLES`, default 2: cycles the DUT reset is driven low per Reset instruction (≥1).
- `CONF_CYCLES`, default 1: cycles `conf_done` is held high per Configure (≥1).
- `GAP_CYCLES`, default 1: idle cycles after each instruction before the next is accepted (≥0).

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, synchronous, active-high.
- `instr_valid` in 1: instruction request valid.
- `instr_ready` out 1: encoder can accept an instruction.
- `instr_op` in 2: 0 = Reset, 1 = Configure, 2/3 illegal.
- `instr_conf_num_{hidden,loops,movies,testusers,users,visible}` in 32 each: Configure payload.
- `dut_rst` out 1: DUT reset, active-low (low = Reset instruction).
- `dut_conf_done` out 1: DUT configuration strobe.
- `dut_conf_num_{hidden,loops,movies,testusers,users,visible}` out 32 each: DUT configuration values.
- `issue` out 1: one-cycle strobe on the first drive cycle of each instruction.
- `prev_reset`, `prev_conf` out 1 each: op of the last issued instruction.
- `err_seq` out 1: one-cycle pulse when a Configure is rejected for ordering.
- `err_op` out 1: one-cycle pulse when an illegal opcode is rejected.
- `instr_count` out 16: number of issued instructions, wraps at 0xFFFF→0.

## Operation
- FSM states: IDLE, RST_DRV, CONF_DRV, GAP.
- IDLE:
  - `instr_ready`=1, `dut_rst`=1, `dut_conf_done`=0.
  - A handshake (`instr_valid` && `instr_ready`) is accepted.
- Handshake with op=0: enter RST_DRV with the counter loaded to RST_CYCLES-1.
- Handshake with op=1:
  - If `prev_conf`=1, reject: `err_seq` pulses, state stays IDLE, no DUT activity.
  - Otherwise latch all six payload fields into `dut_conf_num_*` and enter CONF_DRV with the counter loaded to CONF_CYCLES-1.
- Handshake with op=2/3: `err_op` pulses, state stays IDLE, no DUT activity, flags unchanged.
- RST_DRV: `dut_rst`=0, `dut_conf_done`=0. When the counter reaches 0, go to GAP, or to IDLE if GAP_CYCLES=0.
- CONF_DRV: `dut_rst`=1, `dut_conf_done`=1. When the counter reaches 0, go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: `dut_rst`=1, `dut_conf_done`=0. After GAP_CYCLES cycles, go to IDLE.
- `dut_conf_num_*` change only on an accepted legal Configure and are held otherwise, including across Reset instructions.
- On each `issue` cycle:
  - `prev_reset` ← (op==0), `prev_conf` ← (op==1).
  - `instr_count` increments; rejected instructions do not count.
- `instr_ready`=0 in every state except IDLE.

## Timing
- All outputs are registered.
- Reset values: `dut_rst`=0 (DUT held in reset while the block is in reset), `dut_conf_done`=0, all `dut_conf_num_*`=0, `issue`=0, `prev_reset`=0, `prev_conf`=0, `err_seq`=0, `err_op`=0, `instr_count`=0, `instr_ready`=0, state IDLE.
- First cycle after reset deasserts: `instr_ready`=1, `dut_rst`=1.
- Handshake at cycle T:
  - `issue`=1 and DUT drive begin at T+1.
  - `instr_ready` returns at T+1+RST_CYCLES+GAP_CYCLES (Reset) or T+1+CONF_CYCLES+GAP_CYCLES (Configure).
- A rejected instruction at T: error pulse at T+1, `instr_ready` stays 1, so the next handshake may occur at T+1.
- `rst` asserted mid-instruction: the next cycle returns to reset values (FSM to IDLE, `dut_rst`=0, `dut_conf_done`=0, flags and count cleared).
- `instr_count` 0xFFFF + issue → 0x0000.

## Test plan
- Reset then Configure (payloads 0x10,0x5,0x64,0x2,0x3,0x20), defaults:
  - `dut_rst` low exactly 2 cycles.
  - One gap cycle.
  - `dut_conf_done` high 1 cycle with all six values driven.
  - `issue` pulses twice; `instr_count`=2; `prev_conf`=1.
- Configure as the first instruction after reset → accepted; `issue`=1 at T+1; `prev_conf`=1; `err_seq`=0.
- Configure, Configure:
  - Second Configure gives `err_seq` pulse one cycle after its handshake.
  - No `dut_conf_done`, `dut_conf_num_*` unchanged, `instr_count`=1.
- `instr_op`=3 → `err_op` single pulse, `dut_rst`=1, count unchanged, `instr_ready` still 1.
- `rst` asserted in the second RST_DRV cycle (RST_CYCLES=4) → next cycle all outputs at reset values; after release a Configure is accepted.
- GAP_CYCLES=0, back-to-back Reset handshakes with `instr_valid` held high → `instr_ready` high every RST_CYCLES+1 cycles; preload count 0xFFFF → wraps to 0.
